// File: rtl/spi_boot_fifo_pkg.sv
// Shared boot-path definitions: write-enable encodings seen by the memory
// controller and the default geometry of the boot image path.
package spi_boot_fifo_pkg;

    // Write-enable request encodings, shared with the memory controller.
    localparam logic [1:0] WE_IDLE  = 2'b00;
    localparam logic [1:0] WE_WRITE = 2'b11;

    // Default geometry of the boot path.
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 8;
    localparam int unsigned DEFAULT_BOOT_WORDS = 8192;

endpackage : spi_boot_fifo_pkg

// File: rtl/spi_boot_fifo_sync_word_fifo.sv
// Synchronous word FIFO with a registered read-data output.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   push_i         write request; wdata_i is captured when accepted
//   wdata_i        word to store
//   pop_i          read strobe; head moves to rdata_o on the same edge
//   rdata_o        registered word last popped
//   empty_o        registered, count == 0
//   full_o         registered, count == DEPTH
//   overflow_o     sticky, a push was refused
//   pop_fire_c_o   combinational, this cycle's pop is honoured
//   empty_next_c_o combinational, count will be 0 after this edge
module spi_boot_fifo_sync_word_fifo
    import spi_boot_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int unsigned PTR_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  pop_fire_c_o,
    output logic                  empty_next_c_o
);

    localparam int unsigned CW = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  empty_q, full_q, overflow_q, overflow_d;
    logic                  do_push, do_pop;

    // Accept/pop decisions and next-state; a full FIFO still accepts when a
    // pop frees the head slot on the same edge.
    always_comb begin
        do_pop     = pop_i && (count_q != '0);
        do_push    = push_i && ((count_q != CW'(DEPTH)) || pop_i);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rdata_d    = rdata_q;
        overflow_d = overflow_q | (push_i & ~do_push);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CW'(DEPTH));
            overflow_q <= overflow_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o        = rdata_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign overflow_o     = overflow_q;
    assign pop_fire_c_o   = do_pop;
    assign empty_next_c_o = (count_d == '0);

endmodule : spi_boot_fifo_sync_word_fifo

// File: rtl/spi_boot_fifo.sv
// SPI boot byte packer and word FIFO feeding the boot memory controller.
// Bytes are packed LSB-first into words, buffered, and popped on the
// controller's read strobe; delivered words are counted to flag boot done.
//
// Ports:
//   boot_fifo_clk_i   clock, rising edge
//   boot_fifo_rst_i   synchronous active-high reset
//   spi_byte_i        received SPI byte
//   spi_byte_valid_i  one-cycle strobe, spi_byte_i valid
//   read_fifo_i       pop strobe from the memory controller
//   fifo_data_o       registered word last popped
//   write_enable_o    WE_WRITE while words remain and boot not done
//   spi_hold_o        FIFO full
//   fifo_empty_o      FIFO empty
//   fifo_overflow_o   sticky, a packed word was dropped
//   boot_done_o       sticky, BOOT_WORDS words popped
module spi_boot_fifo
    import spi_boot_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned BOOT_WORDS = DEFAULT_BOOT_WORDS,
    parameter int unsigned CNT_WIDTH  = 14
) (
    input  logic                  boot_fifo_clk_i,
    input  logic                  boot_fifo_rst_i,
    input  logic [7:0]            spi_byte_i,
    input  logic                  spi_byte_valid_i,
    input  logic                  read_fifo_i,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic [1:0]            write_enable_o,
    output logic                  spi_hold_o,
    output logic                  fifo_empty_o,
    output logic                  fifo_overflow_o,
    output logic                  boot_done_o
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [1:0]            we_q, we_d;
    logic                  last_byte, push_c, pop_fire_c, empty_next_c;

    // Packer: drop the incoming byte into its lane; the last lane completes
    // the word, which is pushed combinationally on the same edge.
    always_comb begin
        pack_d     = pack_q;
        byte_idx_d = byte_idx_q;
        last_byte  = (byte_idx_q == IDX_W'(NBYTES - 1));
        push_c     = 1'b0;
        if (spi_byte_valid_i) begin
            pack_d[{byte_idx_q, 3'b000} +: 8] = spi_byte_i;
            push_c     = last_byte;
            byte_idx_d = last_byte ? '0 : byte_idx_q + IDX_W'(1);
        end
    end

    spi_boot_fifo_sync_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_fifo (
        .clk_i          (boot_fifo_clk_i),
        .rst_i          (boot_fifo_rst_i),
        .push_i         (push_c),
        .wdata_i        (pack_d),
        .pop_i          (read_fifo_i),
        .rdata_o        (fifo_data_o),
        .empty_o        (fifo_empty_o),
        .full_o         (spi_hold_o),
        .overflow_o     (fifo_overflow_o),
        .pop_fire_c_o   (pop_fire_c),
        .empty_next_c_o (empty_next_c)
    );

    // Delivered counter saturates at BOOT_WORDS; the request is precomputed
    // from next-state so write_enable_o comes straight from a flop.
    always_comb begin
        cnt_d = cnt_q;
        if (pop_fire_c && (cnt_q != CNT_WIDTH'(BOOT_WORDS))) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        done_d = done_q | (cnt_d == CNT_WIDTH'(BOOT_WORDS));
        we_d   = (!empty_next_c && !done_d) ? WE_WRITE : WE_IDLE;
    end

    always_ff @(posedge boot_fifo_clk_i) begin
        if (boot_fifo_rst_i) begin
            byte_idx_q <= '0;
            pack_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            we_q       <= WE_IDLE;
        end else begin
            byte_idx_q <= byte_idx_d;
            pack_q     <= pack_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            we_q       <= we_d;
        end
    end

    assign write_enable_o = we_q;
    assign boot_done_o    = done_q;

endmodule : spi_boot_fifo

// File: tb/tb_spi_boot_fifo.sv
module tb_spi_boot_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        bvalid = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  bdat = 8'h00;

    logic [31:0] data, s_data;
    logic [1:0]  we, s_we;
    logic        hold, s_hold, empty, s_empty, ovf, s_ovf, done, s_done;

    spi_boot_fifo dut (
        .boot_fifo_clk_i (clk),
        .boot_fifo_rst_i (rst),
        .spi_byte_i      (bdat),
        .spi_byte_valid_i(bvalid),
        .read_fifo_i     (rd),
        .fifo_data_o     (data),
        .write_enable_o  (we),
        .spi_hold_o      (hold),
        .fifo_empty_o    (empty),
        .fifo_overflow_o (ovf),
        .boot_done_o     (done)
    );

    spi_boot_fifo #(.BOOT_WORDS(4)) dut_s (
        .boot_fifo_clk_i (clk),
        .boot_fifo_rst_i (rst),
        .spi_byte_i      (bdat),
        .spi_byte_valid_i(bvalid),
        .read_fifo_i     (rd),
        .fifo_data_o     (s_data),
        .write_enable_o  (s_we),
        .spi_hold_o      (s_hold),
        .fifo_empty_o    (s_empty),
        .fifo_overflow_o (s_ovf),
        .boot_done_o     (s_done)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] m_word = 32'h0;
    int          m_idx = 0;
    logic [31:0] last_pop = 32'h0;

    // One clock of stimulus; the scoreboard queue models the FIFO and hands
    // back the word the DUT should present after this edge.
    task automatic cycle(input logic v, input logic [7:0] bv, input logic r,
                         output logic [31:0] exp);
        int pre;
        pre = sb.size();
        exp = last_pop;
        if (r && pre > 0) begin
            exp = sb.pop_front();
            last_pop = exp;
        end
        if (v) begin
            m_word[m_idx*8 +: 8] = bv;
            if (m_idx == 3) begin
                if (pre < 8 || r) sb.push_back(m_word);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        bvalid = v; bdat = bv; rd = r;
        @(posedge clk); #1;
        bvalid = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_idx = 0;
        m_word = 32'h0;
        last_pop = 32'h0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) cycle(1'b1, w[i*8 +: 8], 1'b0, e);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (data !== 32'h0)  begin n_err++; $display("FAIL reset_data: got %h want 0", data); end
        n_cmp++; if (we !== 2'b00)    begin n_err++; $display("FAIL reset_we: got %b want 00", we); end
        n_cmp++; if (hold !== 1'b0)   begin n_err++; $display("FAIL reset_hold: got %b want 0", hold); end
        n_cmp++; if (empty !== 1'b1)  begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (ovf !== 1'b0)    begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_single();
        logic [31:0] e;
        do_reset();
        send_word(32'h44332211);
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", empty); end
        n_cmp++; if (we !== 2'b11)   begin n_err++; $display("FAIL single_we: got %b want 11", we); end
        cycle(1'b0, 8'h00, 1'b1, e);
        n_cmp++; if (data !== e)     begin n_err++; $display("FAIL single_data: got %h want %h", data, e); end
        n_cmp++; if (data !== 32'h44332211) begin n_err++; $display("FAIL single_const: got %h want 44332211", data); end
        n_cmp++; if (we !== 2'b00)   begin n_err++; $display("FAIL single_we_idle: got %b want 00", we); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_partial_reset();
        logic [31:0] e;
        do_reset();
        cycle(1'b1, 8'h01, 1'b0, e);
        cycle(1'b1, 8'h02, 1'b0, e);
        cycle(1'b1, 8'h03, 1'b0, e);
        do_reset();
        send_word(32'hDDCCBBAA);
        cycle(1'b0, 8'h00, 1'b1, e);
        n_cmp++; if (data !== 32'hDDCCBBAA) begin n_err++; $display("FAIL partial_data: got %h want ddccbbaa", data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL partial_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) send_word($urandom);
        n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL full_hold: got %b want 1", hold); end
        n_cmp++; if (ovf !== 1'b0)  begin n_err++; $display("FAIL full_no_ovf: got %b want 0", ovf); end
        send_word($urandom);
        n_cmp++; if (ovf !== 1'b1)  begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b want 1", hold); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1, e);
            n_cmp++; if (data !== e) begin n_err++; $display("FAIL ovf_pop%0d: got %h want %h", i, data, e); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained: got %b want 1", empty); end
        n_cmp++; if (ovf !== 1'b1)   begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] e, w;
        do_reset();
        for (int i = 0; i < 8; i++) send_word($urandom);
        w = $urandom;
        for (int i = 0; i < 3; i++) cycle(1'b1, w[i*8 +: 8], 1'b0, e);
        cycle(1'b1, w[31:24], 1'b1, e);
        n_cmp++; if (data !== e)    begin n_err++; $display("FAIL pp_data: got %h want %h", data, e); end
        n_cmp++; if (ovf !== 1'b0)  begin n_err++; $display("FAIL pp_ovf: got %b want 0", ovf); end
        n_cmp++; if (hold !== 1'b1) begin n_err++; $display("FAIL pp_hold: got %b want 1", hold); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1, e);
            n_cmp++; if (data !== e) begin n_err++; $display("FAIL pp_pop%0d: got %h want %h", i, data, e); end
        end
        n_cmp++; if (e !== w) begin n_err++; $display("FAIL pp_last_is_new: got %h want %h", e, w); end
    endtask

    task automatic test_pop_empty();
        logic [31:0] e;
        do_reset();
        send_word(32'hCAFE0001);
        cycle(1'b0, 8'h00, 1'b1, e);
        n_cmp++; if (s_data !== e) begin n_err++; $display("FAIL pe_first: got %h want %h", s_data, e); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 1'b1, e);
            n_cmp++; if (s_data !== 32'hCAFE0001) begin n_err++; $display("FAIL pe_hold%0d: got %h want cafe0001", i, s_data); end
            n_cmp++; if (s_done !== 1'b0) begin n_err++; $display("FAIL pe_done%0d: got %b want 0", i, s_done); end
        end
        for (int i = 0; i < 3; i++) begin
            send_word($urandom);
            n_cmp++; if (s_done !== 1'b0) begin n_err++; $display("FAIL pe_early_done%0d: got %b want 0", i, s_done); end
            cycle(1'b0, 8'h00, 1'b1, e);
            n_cmp++; if (s_data !== e) begin n_err++; $display("FAIL pe_pop%0d: got %h want %h", i, s_data, e); end
        end
        n_cmp++; if (s_done !== 1'b1) begin n_err++; $display("FAIL pe_done_after4: got %b want 1", s_done); end
    endtask

    task automatic test_boot_done();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) send_word($urandom);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, e);
            n_cmp++; if (s_data !== e) begin n_err++; $display("FAIL bd_pop%0d: got %h want %h", i, s_data, e); end
            if (i < 3) begin
                n_cmp++; if (s_done !== 1'b0) begin n_err++; $display("FAIL bd_early%0d: got %b want 0", i, s_done); end
                n_cmp++; if (s_we !== 2'b11)  begin n_err++; $display("FAIL bd_we%0d: got %b want 11", i, s_we); end
            end
        end
        n_cmp++; if (s_done !== 1'b1)  begin n_err++; $display("FAIL bd_done: got %b want 1", s_done); end
        n_cmp++; if (s_we !== 2'b00)   begin n_err++; $display("FAIL bd_we_forced: got %b want 00", s_we); end
        n_cmp++; if (s_empty !== 1'b0) begin n_err++; $display("FAIL bd_not_empty: got %b want 0", s_empty); end
        n_cmp++; if (we !== 2'b11)     begin n_err++; $display("FAIL bd_big_we: got %b want 11", we); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL bd_big_done: got %b want 0", done); end
        cycle(1'b0, 8'h00, 1'b1, e);
        n_cmp++; if (s_data !== e)     begin n_err++; $display("FAIL bd_pop5: got %h want %h", s_data, e); end
        n_cmp++; if (s_done !== 1'b1)  begin n_err++; $display("FAIL bd_sticky: got %b want 1", s_done); end
        send_word(32'h12345678);
        n_cmp++; if (s_empty !== 1'b0) begin n_err++; $display("FAIL bd_store_after: got %b want 0", s_empty); end
        n_cmp++; if (s_we !== 2'b00)   begin n_err++; $display("FAIL bd_we_after: got %b want 00", s_we); end
        cycle(1'b0, 8'h00, 1'b1, e);
        n_cmp++; if (s_data !== 32'h12345678) begin n_err++; $display("FAIL bd_after_data: got %h want 12345678", s_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial_reset();
        test_full_overflow();
        test_push_pop_full();
        test_pop_empty();
        test_boot_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spi_boot_fifo

// File: doc/spi_boot_fifo.md
Name: spi_boot_fifo

Overview:
- Upstream stage of the boot memory controller.
- Receives the byte stream from the SPI boot receiver and packs each group of 4 bytes into one 32-bit word, least-significant byte first.
- Buffers the words in a small synchronous FIFO.
- Drives the controller's write-enable request, and presents the next word on a registered output each time the controller pulses its FIFO read strobe.
- Counts the words delivered and flags completion of the boot image.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- FIFO_DEPTH, 8, number of word entries; power of 2.
- PTR_WIDTH, 3, log2(FIFO_DEPTH).
- BOOT_WORDS, 8192, number of words in the boot image (matches the 13-bit SRAM address space).
- CNT_WIDTH, 14, width of the delivered-word counter; must hold BOOT_WORDS.

Ports:
- boot_fifo_clk_i  in  1  clock; all state updates on the rising edge.
- boot_fifo_rst_i  in  1  synchronous, active-high reset.
- spi_byte_i  in  8  received SPI byte.
- spi_byte_valid_i  in  1  one-cycle strobe; spi_byte_i is valid.
- read_fifo_i  in  1  pop strobe from the memory controller; each cycle it is high pops one word.
- fifo_data_o  out  DATA_WIDTH  registered word last popped; feeds the controller's FIFO data input.
- write_enable_o  out  2  2'b11 = word available, request an SRAM write sequence; 2'b00 = idle.
- spi_hold_o  out  1  backpressure to the SPI receiver; high when the FIFO is full.
- fifo_empty_o  out  1  word count == 0.
- fifo_overflow_o  out  1  sticky; a packed word was dropped.
- boot_done_o  out  1  sticky; BOOT_WORDS words have been popped.

Behaviour:
- Reset (synchronous, active-high, one clock): byte index, pointers, word count and delivered counter go to 0. Outputs after reset: fifo_data_o = 0, write_enable_o = 2'b00, spi_hold_o = 0, fifo_empty_o = 1, fifo_overflow_o = 0, boot_done_o = 0. Reset asserted mid-operation discards any partial word and all FIFO contents.
- Packer:
  - byte_idx is 2 bits (0..3). On spi_byte_valid_i, byte i is stored in bits [8i+7:8i] and byte_idx increments, wrapping 3 -> 0.
  - On the 4th byte, the assembled word (including the byte arriving that cycle) is pushed in the same cycle.
  - A partial word stays in the packer indefinitely. It is never flushed.
- Push:
  - Accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and read_fifo_i is high in the same cycle.
  - Otherwise the word is dropped and fifo_overflow_o sets. The packer still wraps to 0.
- Pop:
  - On read_fifo_i with count > 0: the head entry is written to fifo_data_o on that edge, the read pointer advances and the delivered counter increments.
  - Latency: fifo_data_o shows the new word 1 cycle after the strobe. It is therefore stable during the controller's later SRAM write phase.
  - Pop when empty is ignored: fifo_data_o holds, counters unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- A push into an empty FIFO is not readable in the same cycle; it becomes poppable one cycle later.
- write_enable_o = 2'b11 when count != 0 and boot_done_o == 0, else 2'b00.
  - Decoded from registers only; no combinational path from inputs.
  - The controller samples it once per 8-cycle write sequence, so holding the request high while words remain is legal.
- spi_hold_o = (count == FIFO_DEPTH). fifo_empty_o = (count == 0).
- Delivered counter:
  - Saturates at BOOT_WORDS.
  - boot_done_o sets on the edge where the counter reaches BOOT_WORDS and stays set until reset.
  - Once done, write_enable_o forces 2'b00. Further pops are still honoured, but the counter does not increment.
  - Bytes arriving after done are still packed and stored.

Decomposition:
- Shared boot package holds:
  - WE_IDLE = 2'b00 and WE_WRITE = 2'b11 encodings, shared with the memory controller.
  - Default DATA_WIDTH and BOOT_WORDS constants.
- One natural sub-module: sync_word_fifo (pointers, count, storage, registered output).
- The packer and the delivered counter stay in the top level.

Test Plan:
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 -> one entry stored, fifo_empty_o = 0, write_enable_o = 2'b11; pop -> fifo_data_o = 0x44332211 one cycle later, write_enable_o = 2'b00.
- 3 bytes then reset, then 4 bytes 0xAA..0xDD -> partial discarded; popped word = 0xDDCCBBAA.
- Push 8 words without popping -> spi_hold_o = 1; a 9th word -> fifo_overflow_o = 1, count stays 8; 8 pops return the first 8 words in order.
- With FIFO full, 4th byte arrives in the same cycle as read_fifo_i -> no overflow, count stays 8, order preserved.
- Pop while empty -> fifo_data_o unchanged, delivered counter unchanged.
- BOOT_WORDS = 4: push and pop 4 words -> boot_done_o sets on the 4th pop and write_enable_o = 2'b00 even with a 5th word stored.
